rib_arbiter: RTL and testbench

Bus arbiter for the RIB interconnect. Shares the single RIB slave port between up to NUM_MASTERS requesters: core load/store, instruction fetch, DMA and JTAG debug. JTAG has absolute priority and the rest are served round-robin. It registers a one-hot grant, tracks each granted transaction until the slave acknowledges it, supports locked multi-beat ownership, and aborts hung transfers on timeout. It also drives the hold request that the pipeline controller turns into a PC stall.

---
 rtl/rib_pkg.sv | 22 ++
 rtl/rib_arbiter_rr_picker.sv | 31 +++
 rtl/rib_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rib_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rib_pkg.sv
// Shared RIB arbiter types, defaults and small index helpers.
package rib_pkg;

   localparam int unsigned RIB_NUM_MASTERS_DEF = 4;
   localparam int unsigned RIB_TIMEOUT_DEF     = 16;
   localparam int unsigned RIB_JTAG_IDX        = RIB_NUM_MASTERS_DEF - 1;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // JTAG always sits on the highest master index.
   function automatic int unsigned rib_jtag_idx(input int unsigned num_masters);
      return num_masters - 1;
   endfunction

   function automatic int unsigned rib_wrap_inc(input int unsigned idx, input int unsigned n);
      return ((idx + 1) >= n) ? 0 : (idx + 1);
   endfunction

endpackage

// File: rtl/rib_arbiter_rr_picker.sv
// Masked round-robin priority encoder: first requester at or after ptr_i, wrapping.
module rr_picker #(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   logic [N-1:0] low_mask;
   logic [N-1:0] masked;
   logic [N-1:0] sel;

   // Requests at or above the pointer take precedence; otherwise wrap to the bottom.
   assign low_mask = (N'(1) << ptr_i) - N'(1);
   assign masked   = req_i & ~low_mask;
   assign sel      = (|masked) ? masked : req_i;
   assign gnt_o    = sel & (~sel + N'(1));
   assign valid_o  = |req_i;

   always_comb begin
      idx_o = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (gnt_o[i]) idx_o = IW'(i);
      end
   end

endmodule

// File: rtl/rib_arbiter.sv
// RIB slave-port arbiter: JTAG absolute priority, round-robin for the rest, lock and timeout.
module rib_arbiter
   import rib_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = RIB_NUM_MASTERS_DEF,
   parameter int unsigned TIMEOUT     = RIB_TIMEOUT_DEF
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_MASTERS-1:0]         req_i,
   input  logic [NUM_MASTERS-1:0]         lock_i,
   input  logic                           slv_ack_i,
   output logic [NUM_MASTERS-1:0]         gnt_o,
   output logic [$clog2(NUM_MASTERS)-1:0] gnt_id_o,
   output logic                           busy_o,
   output logic                           err_o,
   output logic                           hold_flag_rib_o
);

   localparam int unsigned IDW  = $clog2(NUM_MASTERS);
   localparam int unsigned CW   = $clog2(TIMEOUT + 1);
   localparam int unsigned RRN  = NUM_MASTERS - 1;
   localparam int unsigned JTAG = rib_jtag_idx(NUM_MASTERS);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]         gnt_id_q, gnt_id_d;
   logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;

   logic                   owner_req;
   logic                   owner_lock;
   logic                   owner_jtag;
   logic                   ack_release;
   logic [IDW-1:0]         ptr_next;
   logic [IDW-1:0]         ptr_arb;
   logic [NUM_MASTERS-1:0] arb_req;
   logic [RRN-1:0]         pick_gnt;
   logic [IDW-1:0]         pick_idx;
   logic                   pick_valid;
   logic [NUM_MASTERS-1:0] win_gnt;
   logic [IDW-1:0]         win_id;
   logic                   win_valid;

   assign owner_req   = |(req_i & gnt_q);
   assign owner_lock  = |(lock_i & gnt_q);
   assign owner_jtag  = gnt_q[JTAG];
   assign ack_release = (state_q == ARB_BUSY) && slv_ack_i && !owner_lock;
   assign ptr_next    = IDW'(rib_wrap_inc(32'(gnt_id_q), RRN));

   // The releasing owner is masked out and the pointer already steps past it.
   assign arb_req = req_i & ~gnt_q;
   assign ptr_arb = (ack_release && !owner_jtag) ? ptr_next : rr_ptr_q;

   rr_picker #(
      .N  (RRN),
      .IW (IDW)
   ) u_rr_picker (
      .req_i   (arb_req[RRN-1:0]),
      .ptr_i   (ptr_arb),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   always_comb begin
      win_gnt   = '0;
      win_id    = '0;
      win_valid = 1'b0;
      if (arb_req[JTAG]) begin
         win_gnt[JTAG] = 1'b1;
         win_id        = IDW'(JTAG);
         win_valid     = 1'b1;
      end else if (pick_valid) begin
         win_gnt   = NUM_MASTERS'(pick_gnt);
         win_id    = pick_idx;
         win_valid = 1'b1;
      end
   end

   // Next-state: ack beats drop-out beats timeout while busy.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (win_valid) begin
               state_d  = ARB_BUSY;
               gnt_d    = win_gnt;
               gnt_id_d = win_id;
               cnt_d    = '0;
            end
         end
         ARB_BUSY: begin
            if (slv_ack_i) begin
               cnt_d = '0;
               if (!owner_lock) begin
                  if (!owner_jtag) rr_ptr_d = ptr_next;
                  if (win_valid) begin
                     gnt_d    = win_gnt;
                     gnt_id_d = win_id;
                  end else begin
                     state_d  = ARB_IDLE;
                     gnt_d    = '0;
                     gnt_id_d = '0;
                  end
               end
            end else if (!owner_req) begin
               state_d  = ARB_IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
               cnt_d    = '0;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d  = ARB_IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
               cnt_d    = '0;
               err_d    = 1'b1;
               if (!owner_jtag) rr_ptr_d = ptr_next;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
         end
      endcase
      busy_d = |gnt_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ARB_IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign gnt_o           = gnt_q;
   assign gnt_id_o        = gnt_id_q;
   assign busy_o          = busy_q;
   assign err_o           = err_q;
   assign hold_flag_rib_o = req_i[0] & ~gnt_q[0];

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter (4 masters, timeout 16).
module tb_rib_arbiter;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [3:0] req_i;
   logic [3:0] lock_i;
   logic       slv_ack_i;
   logic [3:0] gnt_o;
   logic [1:0] gnt_id_o;
   logic       busy_o;
   logic       err_o;
   logic       hold_flag_rib_o;

   int n_pass  = 0;
   int n_total = 0;
   int order [6] = '{0, 1, 2, 0, 1, 2};

   rib_arbiter #(
      .NUM_MASTERS (4),
      .TIMEOUT     (16)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .req_i           (req_i),
      .lock_i          (lock_i),
      .slv_ack_i       (slv_ack_i),
      .gnt_o           (gnt_o),
      .gnt_id_o        (gnt_id_o),
      .busy_o          (busy_o),
      .err_o           (err_o),
      .hold_flag_rib_o (hold_flag_rib_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_i     = 1'b1;
      req_i     = '0;
      lock_i    = '0;
      slv_ack_i = 1'b0;
      step();
      rst_i = 1'b0;
   endtask

   initial begin
      do_reset();
      rst_i = 1'b1;
      step();
      check("rst_gnt",  32'(gnt_o),    32'h0);
      check("rst_id",   32'(gnt_id_o), 32'h0);
      check("rst_busy", 32'(busy_o),   32'h0);
      check("rst_err",  32'(err_o),    32'h0);
      req_i = 4'b0001;
      #1;
      check("rst_hold", 32'(hold_flag_rib_o), 32'h1);
      req_i = '0;
      rst_i = 1'b0;
      step();

      // Basic grant and ack
      req_i = 4'b0001;
      #1;
      check("basic_hold_wait", 32'(hold_flag_rib_o), 32'h1);
      step();
      check("basic_gnt",  32'(gnt_o),           32'h1);
      check("basic_busy", 32'(busy_o),          32'h1);
      check("basic_hold", 32'(hold_flag_rib_o), 32'h0);
      step();
      step();
      slv_ack_i = 1'b1;
      step();
      slv_ack_i = 1'b0;
      req_i     = '0;
      check("basic_release", 32'(gnt_o),  32'h0);
      check("basic_idle",    32'(busy_o), 32'h0);

      // Round-robin with JTAG override
      do_reset();
      req_i = 4'b0111;
      step();
      for (int i = 0; i < 6; i++) begin
         if (i == 5) req_i = 4'b1111;
         check("rr_gnt",  32'(gnt_o),           32'(1) << order[i]);
         check("rr_id",   32'(gnt_id_o),        32'(order[i]));
         check("rr_hold", 32'(hold_flag_rib_o), 32'(order[i] != 0));
         step();
         slv_ack_i = 1'b1;
         step();
         slv_ack_i = 1'b0;
      end
      check("jtag_gnt",  32'(gnt_o),           32'h8);
      check("jtag_id",   32'(gnt_id_o),        32'h3);
      check("jtag_hold", 32'(hold_flag_rib_o), 32'h1);
      step();
      slv_ack_i = 1'b1;
      step();
      slv_ack_i = 1'b0;
      check("after_jtag_gnt", 32'(gnt_o), 32'h1);

      // Abort: owner drops request without ack
      req_i = '0;
      step();
      check("abort_gnt",  32'(gnt_o),  32'h0);
      check("abort_err",  32'(err_o),  32'h0);
      check("abort_busy", 32'(busy_o), 32'h0);

      // Lock holds ownership against pending JTAG
      req_i  = 4'b0010;
      lock_i = 4'b0010;
      step();
      check("lock_gnt", 32'(gnt_o), 32'h2);
      req_i = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         slv_ack_i = 1'b1;
         step();
         slv_ack_i = 1'b0;
         check("lock_hold_gnt", 32'(gnt_o), 32'h2);
         step();
      end
      lock_i    = '0;
      slv_ack_i = 1'b1;
      step();
      slv_ack_i = 1'b0;
      check("unlock_jtag_gnt", 32'(gnt_o), 32'h8);
      req_i = '0;
      step();
      check("unlock_idle", 32'(gnt_o), 32'h0);

      // Timeout on master 2
      req_i = 4'b0100;
      step();
      check("to_gnt", 32'(gnt_o), 32'h4);
      repeat (15) step();
      check("to_err_early", 32'(err_o), 32'h0);
      check("to_gnt_early", 32'(gnt_o), 32'h4);
      step();
      check("to_err",  32'(err_o),  32'h1);
      check("to_drop", 32'(gnt_o),  32'h0);
      check("to_busy", 32'(busy_o), 32'h0);
      req_i = 4'b0111;
      step();
      check("to_err_pulse", 32'(err_o), 32'h0);
      check("to_ptr_adv",   32'(gnt_o), 32'h1);
      req_i = '0;
      step();
      check("to_clean", 32'(gnt_o), 32'h0);

      // Ack coincident with timeout wins
      req_i = 4'b0100;
      step();
      check("toack_gnt", 32'(gnt_o), 32'h4);
      repeat (15) step();
      slv_ack_i = 1'b1;
      step();
      slv_ack_i = 1'b0;
      req_i     = '0;
      check("toack_err", 32'(gnt_o) | 32'(err_o), 32'h0);
      step();
      check("toack_err2", 32'(err_o), 32'h0);

      // Reset during a locked beat, then re-sample
      req_i  = 4'b0001;
      lock_i = 4'b0001;
      step();
      check("rl_gnt", 32'(gnt_o), 32'h1);
      slv_ack_i = 1'b1;
      step();
      slv_ack_i = 1'b0;
      check("rl_locked", 32'(gnt_o), 32'h1);
      rst_i = 1'b1;
      step();
      check("rl_gnt0", 32'(gnt_o),           32'h0);
      check("rl_id0",  32'(gnt_id_o),        32'h0);
      check("rl_busy", 32'(busy_o),          32'h0);
      check("rl_err",  32'(err_o),           32'h0);
      check("rl_hold", 32'(hold_flag_rib_o), 32'h1);
      rst_i = 1'b0;
      step();
      check("rl_regrant", 32'(gnt_o), 32'h1);
      req_i  = '0;
      lock_i = '0;
      step();
      check("rl_clean", 32'(gnt_o), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
